// File: rtl/ae250_spi_responder_if.sv
// Pin and byte-stream bundle for the AE250 SPI responder.
// The slave modport is the responder side; the master modport is the SPI master plus the byte agent.
interface ae250_spi_responder_if;
  logic       spi_sclk;
  logic       spi_csn;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       tx_underrun;

  modport slave (
    input  spi_sclk, spi_csn, spi_mosi, tx_data, tx_valid, rx_ready,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );

  modport master (
    output spi_sclk, spi_csn, spi_mosi, tx_data, tx_valid, rx_ready,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/ae250_spi_responder.sv
// Mode-0, MSB-first, 8-bit SPI responder.
// SCLK, CSn and MOSI are oversampled in the clk domain; there is a one-entry TX holding register.
module ae250_spi_responder #(
  parameter logic [7:0] TX_DEFAULT = 8'hFF
) (
  input  logic                        clk,
  input  logic                        rst,
  ae250_spi_responder_if.slave        bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] sclk_sync_r;
  logic [2:0] csn_sync_r;
  logic [1:0] mosi_sync_r;
  logic [7:0] tx_shift_r;
  logic [7:0] tx_hold_r;
  logic       tx_full_r;
  logic [6:0] rx_shift_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       rx_overrun_r;
  logic       tx_underrun_r;
  logic [2:0] bit_cnt_r;

  logic       sclk_rise_s, sclk_fall_s, csn_rise_s, csn_fall_s, mosi_s;
  logic       start_s, rise_act_s, fall_act_s, load_s, byte_done_s;
  logic       tx_write_s, rx_accept_s, rx_capture_s;
  logic [7:0] rx_byte_s;
  logic       miso_s, miso_oe_s;

  // Two sync flops per pin; the third SCLK/CSn flop is the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= 3'b000;
      csn_sync_r  <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], bus.spi_sclk};
      csn_sync_r  <= {csn_sync_r[1:0], bus.spi_csn};
      mosi_sync_r <= {mosi_sync_r[0], bus.spi_mosi};
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign csn_rise_s  = csn_sync_r[1] & ~csn_sync_r[2];
  assign csn_fall_s  = ~csn_sync_r[1] & csn_sync_r[2];
  assign mosi_s      = mosi_sync_r[1];

  // Deselect wins over any SCLK edge seen in the same cycle.
  assign start_s      = (state_r == IDLE) & csn_fall_s;
  assign rise_act_s   = (state_r == ACTIVE) & sclk_rise_s & ~csn_rise_s;
  assign fall_act_s   = (state_r == ACTIVE) & sclk_fall_s & ~csn_rise_s;
  assign load_s       = start_s | (fall_act_s & (bit_cnt_r == 3'd0));
  assign byte_done_s  = rise_act_s & (bit_cnt_r == 3'd7);
  assign rx_byte_s    = {rx_shift_r, mosi_s};
  assign rx_accept_s  = rx_valid_r & bus.rx_ready;
  assign rx_capture_s = byte_done_s & (~rx_valid_r | bus.rx_ready);
  assign tx_write_s   = bus.tx_valid & ~tx_full_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (csn_fall_s) state_nxt_s = ACTIVE;
        else            state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (csn_rise_s) state_nxt_s = IDLE;
        else            state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: MISO is driven only while selected.
  always_comb begin
    miso_s    = 1'b0;
    miso_oe_s = 1'b0;
    case (state_r)
      IDLE: begin
        miso_s    = 1'b0;
        miso_oe_s = 1'b0;
      end
      ACTIVE: begin
        miso_s    = tx_shift_r[7];
        miso_oe_s = 1'b1;
      end
      default: begin
        miso_s    = 1'b0;
        miso_oe_s = 1'b0;
      end
    endcase
  end

  // Shift registers, bit counter, TX holding register and RX port.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r     <= 3'd0;
      tx_shift_r    <= 8'h00;
      tx_hold_r     <= 8'h00;
      tx_full_r     <= 1'b0;
      rx_shift_r    <= 7'h00;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      if (start_s)         bit_cnt_r <= 3'd0;
      else if (rise_act_s) bit_cnt_r <= bit_cnt_r + 3'd1;
      else                 bit_cnt_r <= bit_cnt_r;

      if (rise_act_s) rx_shift_r <= rx_byte_s[6:0];
      else            rx_shift_r <= rx_shift_r;

      // A write landing in a load cycle can only happen when the register was empty.
      if (load_s)          tx_shift_r <= tx_full_r ? tx_hold_r : TX_DEFAULT;
      else if (fall_act_s) tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      else                 tx_shift_r <= tx_shift_r;

      if (tx_write_s)  tx_full_r <= 1'b1;
      else if (load_s) tx_full_r <= 1'b0;
      else             tx_full_r <= tx_full_r;

      if (tx_write_s) tx_hold_r <= bus.tx_data;
      else            tx_hold_r <= tx_hold_r;

      if (rx_capture_s) rx_data_r <= rx_byte_s;
      else              rx_data_r <= rx_data_r;

      if (rx_capture_s)     rx_valid_r <= 1'b1;
      else if (rx_accept_s) rx_valid_r <= 1'b0;
      else                  rx_valid_r <= rx_valid_r;

      rx_overrun_r  <= byte_done_s & rx_valid_r & ~bus.rx_ready;
      tx_underrun_r <= load_s & ~tx_full_r;
    end
  end

  assign bus.spi_miso    = miso_s;
  assign bus.spi_miso_oe = miso_oe_s;
  assign bus.tx_ready    = ~tx_full_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.rx_overrun  = rx_overrun_r;
  assign bus.tx_underrun = tx_underrun_r;

endmodule
